if_stage: RTL

Instruction-fetch stage of the 8-bit RISC-V pipeline. It is the producing end of the IF/ID interface: it owns the PC, a loadable instruction memory and the IF/ID pipeline register, and it drives PC_out and instruction into the decode stage. A small control FSM handles program loading, run, and halt. Branch redirect and stall inputs come from later stages.

---
 rtl/if_stage_pkg.sv | 7 +
 rtl/if_stage_if.sv | 24 ++
 rtl/if_imem.sv | 14 +
 rtl/if_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and FSM encoding for the instruction-fetch stage.
package if_stage_pkg;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam int PC_INC = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: load/control inputs and IF/ID outputs of the fetch stage.
interface if_stage_if #(parameter int PC_SIZE = 10);
    logic               load_en;
    logic [PC_SIZE-3:0] load_addr;
    logic [31:0]        load_data;
    logic               load_done;
    logic               start;
    logic               branch_taken;
    logic [PC_SIZE-1:0] branch_target;
    logic               stall;
    logic [PC_SIZE-1:0] PC_out;
    logic [31:0]        instruction;
    logic               valid;
    logic               halted;
    logic               busy;
    modport master (
        input  load_en, load_addr, load_data, load_done, start, branch_taken, branch_target, stall,
        output PC_out, instruction, valid, halted, busy
    );
    modport slave (
        output load_en, load_addr, load_data, load_done, start, branch_taken, branch_target, stall,
        input  PC_out, instruction, valid, halted, busy
    );
endinterface

// File: rtl/if_imem.sv
// if_imem: instruction memory with one synchronous write port and one combinational read port.
module if_imem #(parameter int AW = 8) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];
    always_ff @(posedge clock)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, loadable IMEM and IF/ID register with an IDLE/LOAD/RUN/HALT control FSM.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int PC_SIZE = 10
) (
    input logic clock,
    input logic reset,
    if_stage_if.master bus
);
    localparam int AW = PC_SIZE - 2;
    localparam logic [PC_SIZE-1:0] LAST_PC = PC_SIZE'((2**AW - 1) * 4);

    state_t state_q, state_d;
    logic [PC_SIZE-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d, rdata;
    logic valid_q, valid_d, halted_q, halted_d, busy_q, busy_d, we;

    if_imem #(.AW(AW)) u_imem (
        .clock(clock),
        .we(we),
        .waddr(bus.load_addr),
        .wdata(bus.load_data),
        .raddr(pc_q[PC_SIZE-1:2]),
        .rdata(rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        pc_out_d = '0;
        instr_d = NOP;
        valid_d = 1'b0;
        we = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (bus.load_en) begin
                    we = 1'b1;
                    state_d = LOAD;
                end else if (bus.start) begin
                    state_d = RUN;
                    pc_d = '0;
                end
            end
            LOAD: begin
                we = bus.load_en;
                if (bus.load_done) state_d = IDLE;
            end
            default: begin
                if (bus.branch_taken) begin
                    pc_d = {bus.branch_target[PC_SIZE-1:2], 2'b00};
                end else if (bus.stall) begin
                    pc_out_d = pc_out_q;
                    instr_d = instr_q;
                    valid_d = valid_q;
                end else if (rdata[6:0] == OPC_SYSTEM) begin
                    state_d = HALT;
                end else begin
                    pc_out_d = pc_q;
                    instr_d = rdata;
                    valid_d = 1'b1;
                    state_d = (pc_q == LAST_PC) ? HALT : RUN;
                    pc_d = (pc_q == LAST_PC) ? '0 : pc_q + PC_SIZE'(PC_INC);
                end
            end
        endcase
        halted_d = state_d == HALT;
        busy_d = state_d == LOAD || state_d == RUN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q <= '0;
            pc_out_q <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            halted_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            halted_q <= halted_d;
            busy_q <= busy_d;
        end
    end

    assign bus.PC_out = pc_out_q;
    assign bus.instruction = instr_q;
    assign bus.valid = valid_q;
    assign bus.halted = halted_q;
    assign bus.busy = busy_q;
endmodule
